conv2_stream: RTL and testbench

Streaming successor to conv2. Accepts one signed pixel per handshake in raster order and holds SIZEKer-1 line buffers plus a SIZEKer x SIZEKer window. Produces a saturated, scaled convolution result per valid window position, with a run-time loadable kernel, a configurable stride and valid/ready backpressure on both sides. It sits between the image source (memory reader or previous layer) and the next layer or result writer.

---
 rtl/conv2_stream.sv | 186 ++++++++++++++++++
 tb/tb_conv2_stream.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv2_stream.sv
// conv2_stream: streaming 2-D convolution over a square signed-pixel frame.
//
// Pixels arrive one per valid/ready handshake in raster order. SIZEKer-1
// line buffers and a SIZEKer x SIZEKer window produce one scaled and
// saturated result per window position that lands on the stride grid.
// The kernel can be loaded at run time while the block is idle.
//
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   start                 one-cycle pulse in IDLE begins a frame
//   ker_we/row/col/data   kernel coefficient write (accepted only in IDLE)
//   pix_valid/ready/data  input pixel stream
//   out_valid/ready/data  output result stream, plus out_row/out_col index
//   busy                  high while a frame is being processed or flushed
//   done                  one-cycle pulse at frame completion
module conv2_stream #(
    parameter int SIZE      = 64,
    parameter int SIZEKer   = 3,
    parameter int WIDTH_BIT = 8,
    parameter int ACC_WIDTH = 2*WIDTH_BIT + $clog2(SIZEKer*SIZEKer),
    parameter int STRIDE    = 1,
    parameter int SHIFT     = 0
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        ker_we,
    input  logic [$clog2(SIZEKer)-1:0]  ker_row,
    input  logic [$clog2(SIZEKer)-1:0]  ker_col,
    input  logic signed [WIDTH_BIT-1:0] ker_data,
    input  logic                        pix_valid,
    output logic                        pix_ready,
    input  logic signed [WIDTH_BIT-1:0] pix_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [WIDTH_BIT-1:0] out_data,
    output logic [$clog2(SIZE)-1:0]     out_row,
    output logic [$clog2(SIZE)-1:0]     out_col,
    output logic                        busy,
    output logic                        done
);

    localparam int CW = $clog2(SIZE);
    localparam int K  = SIZEKer;
    localparam logic [CW-1:0] LAST = CW'(SIZE-1);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    state_t state, state_nx;

    logic [CW-1:0]                row_cnt, col_cnt;
    logic signed [WIDTH_BIT-1:0]  ker    [K][K];
    logic signed [WIDTH_BIT-1:0]  lbuf   [K-1][SIZE];
    logic signed [WIDTH_BIT-1:0]  win    [K][K];
    logic signed [WIDTH_BIT-1:0]  win_nx [K][K];

    logic                         pix_fire, last_pix, emit;
    logic signed [2*WIDTH_BIT-1:0] prod;
    logic signed [ACC_WIDTH-1:0]  acc, acc_sh;
    logic signed [WIDTH_BIT-1:0]  sat;
    logic [CW-1:0]                orow_nx, ocol_nx;
    int                           rowi, coli;

    assign pix_fire = pix_valid && pix_ready;
    assign last_pix = (row_cnt == LAST) && (col_cnt == LAST);

    // State register
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (pix_fire && last_pix) state_nx = FLUSH;
            FLUSH:   if (!out_valid || out_ready) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        pix_ready = (state == RUN) && (!out_valid || out_ready);
        busy      = (state == RUN) || (state == FLUSH);
        done      = (state == DONE);
    end

    // Raster counters and kernel registers
    always_ff @(posedge clock) begin
        if (reset) begin
            row_cnt <= '0;
            col_cnt <= '0;
            for (int unsigned i = 0; i < K; i++)
                for (int unsigned j = 0; j < K; j++)
                    ker[i][j] <= '0;
        end else if (state == IDLE) begin
            row_cnt <= '0;
            col_cnt <= '0;
            if (ker_we && int'(ker_row) < K && int'(ker_col) < K)
                ker[ker_row][ker_col] <= ker_data;
        end else if (pix_fire) begin
            if (col_cnt == LAST) begin
                col_cnt <= '0;
                row_cnt <= row_cnt + 1'b1;
            end else begin
                col_cnt <= col_cnt + 1'b1;
            end
        end
    end

    // Window after the current pixel shifts in: the new column is the
    // line-buffer contents at this column (oldest row on top) plus the pixel.
    always_comb begin
        win_nx = win;
        for (int unsigned i = 0; i < K; i++)
            for (int unsigned j = 0; j + 1 < K; j++)
                win_nx[i][j] = win[i][j+1];
        for (int unsigned i = 0; i + 1 < K; i++)
            win_nx[i][K-1] = lbuf[K-2-i][col_cnt];
        win_nx[K-1][K-1] = pix_data;
    end

    // lbuf[0] holds the previous row; deeper entries hold older rows.
    always_ff @(posedge clock) begin
        if (pix_fire) begin
            win <= win_nx;
            lbuf[0][col_cnt] <= pix_data;
            for (int unsigned k = 1; k + 1 < K; k++)
                lbuf[k][col_cnt] <= lbuf[k-1][col_cnt];
        end
    end

    // Multiply-accumulate, arithmetic scale, saturate
    always_comb begin
        acc  = '0;
        prod = '0;
        for (int unsigned i = 0; i < K; i++) begin
            for (int unsigned j = 0; j < K; j++) begin
                prod = win_nx[i][j] * ker[i][j];
                acc  = acc + ACC_WIDTH'(prod);
            end
        end
        acc_sh = acc >>> SHIFT;
        // In range when every bit above the result sign bit matches it.
        if (&acc_sh[ACC_WIDTH-1:WIDTH_BIT-1] || ~|acc_sh[ACC_WIDTH-1:WIDTH_BIT-1])
            sat = acc_sh[WIDTH_BIT-1:0];
        else if (acc_sh[ACC_WIDTH-1])
            sat = {1'b1, {(WIDTH_BIT-1){1'b0}}};
        else
            sat = {1'b0, {(WIDTH_BIT-1){1'b1}}};
    end

    // Window position test for the pixel currently offered
    always_comb begin
        rowi    = int'(row_cnt);
        coli    = int'(col_cnt);
        emit    = (rowi >= K-1) && (coli >= K-1) &&
                  ((rowi - (K-1)) % STRIDE == 0) &&
                  ((coli - (K-1)) % STRIDE == 0);
        orow_nx = CW'((rowi - (K-1)) / STRIDE);
        ocol_nx = CW'((coli - (K-1)) / STRIDE);
    end

    // Output register; pix_ready guarantees a new result only overwrites
    // a slot that is empty or being accepted this cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_row   <= '0;
            out_col   <= '0;
        end else if (pix_fire && emit) begin
            out_valid <= 1'b1;
            out_data  <= sat;
            out_row   <= orow_nx;
            out_col   <= ocol_nx;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_conv2_stream.sv
module tb_conv2_stream;

    localparam int SZ = 8;
    localparam int K  = 3;
    localparam int W  = 8;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic              reset, start1, start2, ker_we, pix_valid;
    logic              out_ready1, out_ready2;
    logic [1:0]        ker_row, ker_col;
    logic signed [7:0] ker_data, pix_data;

    logic              pr1, ov1, busy1, done1;
    logic signed [7:0] od1;
    logic [2:0]        or1, oc1;
    logic              pr2, ov2, busy2, done2;
    logic signed [7:0] od2;
    logic [2:0]        or2, oc2;

    conv2_stream #(.SIZE(SZ), .SIZEKer(K), .WIDTH_BIT(W), .STRIDE(1), .SHIFT(0)) u_s1 (
        .clock(clock), .reset(reset), .start(start1), .ker_we(ker_we),
        .ker_row(ker_row), .ker_col(ker_col), .ker_data(ker_data),
        .pix_valid(pix_valid), .pix_ready(pr1), .pix_data(pix_data),
        .out_valid(ov1), .out_ready(out_ready1), .out_data(od1),
        .out_row(or1), .out_col(oc1), .busy(busy1), .done(done1)
    );

    conv2_stream #(.SIZE(SZ), .SIZEKer(K), .WIDTH_BIT(W), .STRIDE(2), .SHIFT(2)) u_s2 (
        .clock(clock), .reset(reset), .start(start2), .ker_we(ker_we),
        .ker_row(ker_row), .ker_col(ker_col), .ker_data(ker_data),
        .pix_valid(pix_valid), .pix_ready(pr2), .pix_data(pix_data),
        .out_valid(ov2), .out_ready(out_ready2), .out_data(od2),
        .out_row(or2), .out_col(oc2), .busy(busy2), .done(done2)
    );

    int sel = 1;
    logic              pr_s, ov_s, busy_s, done_s;
    logic signed [7:0] od_s;
    logic [2:0]        or_s, oc_s;
    assign pr_s   = (sel == 2) ? pr2   : pr1;
    assign ov_s   = (sel == 2) ? ov2   : ov1;
    assign busy_s = (sel == 2) ? busy2 : busy1;
    assign done_s = (sel == 2) ? done2 : done1;
    assign od_s   = (sel == 2) ? od2   : od1;
    assign or_s   = (sel == 2) ? or2   : or1;
    assign oc_s   = (sel == 2) ? oc2   : oc1;

    int nvec = 0;
    int nerr = 0;
    int img [SZ][SZ];
    int mk  [K][K];
    int done_cnt;

    typedef struct { int d; int r; int c; } res_t;
    res_t exp_q[$];
    res_t obs_q[$];

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: direct convolution over the stored frame at each stride position.
    task automatic build_expected(input int s, input int sh);
        int n, sum;
        exp_q.delete();
        n = (SZ - K) / s + 1;
        for (int orow = 0; orow < n; orow++) begin
            for (int ocol = 0; ocol < n; ocol++) begin
                sum = 0;
                for (int i = 0; i < K; i++)
                    for (int j = 0; j < K; j++)
                        sum += img[orow*s+i][ocol*s+j] * mk[i][j];
                sum = sum >>> sh;
                if (sum > 127)  sum = 127;
                if (sum < -128) sum = -128;
                exp_q.push_back('{sum, orow, ocol});
            end
        end
    endtask

    task automatic fill_img(input int lo, input int hi);
        for (int r = 0; r < SZ; r++)
            for (int c = 0; c < SZ; c++)
                img[r][c] = int'($urandom_range(0, hi - lo)) + lo;
    endtask

    task automatic fill_ker(input int lo, input int hi);
        for (int i = 0; i < K; i++)
            for (int j = 0; j < K; j++)
                mk[i][j] = int'($urandom_range(0, hi - lo)) + lo;
    endtask

    task automatic load_kernel();
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K; j++) begin
                @(negedge clock);
                ker_we   = 1'b1;
                ker_row  = 2'(i);
                ker_col  = 2'(j);
                ker_data = 8'(mk[i][j]);
            end
        end
        @(negedge clock);
        ker_we = 1'b0;
    endtask

    task automatic run_frame(input int sel_i, input int maxpix, input bit rnd_ready,
                             input bit stall, input bit we_in_run, input bit we_on_start);
        int idx, cyc, post, stall_cnt;
        bit out_r;
        logic signed [31:0] hold_d, hold_r, hold_c;
        sel = sel_i;
        obs_q.delete();
        done_cnt = 0; idx = 0; cyc = 0; post = 0; stall_cnt = 0;
        hold_d = 0; hold_r = 0; hold_c = 0;
        @(negedge clock);
        if (sel_i == 2) start2 = 1'b1; else start1 = 1'b1;
        if (we_on_start) begin
            ker_we = 1'b1; ker_row = 2'd1; ker_col = 2'd1; ker_data = 8'(mk[1][1]);
        end
        @(negedge clock);
        start1 = 1'b0; start2 = 1'b0; ker_we = 1'b0;
        chk("busy_after_start", busy_s, 1);
        while (cyc < 2000 && !(done_cnt > 0 && post >= 3) && !(maxpix > 0 && idx >= maxpix)) begin
            if (stall)          out_r = (stall_cnt >= 5);
            else if (rnd_ready) out_r = ($urandom_range(0, 3) != 0);
            else                out_r = 1'b1;
            out_ready1 = out_r;
            out_ready2 = out_r;
            pix_valid  = (idx < SZ*SZ) && ($urandom_range(0, 4) != 0);
            pix_data   = (idx < SZ*SZ) ? 8'(img[idx/SZ][idx%SZ]) : 8'sd0;
            if (we_in_run && cyc == 10) begin
                ker_we = 1'b1; ker_row = 2'd1; ker_col = 2'd1; ker_data = 8'sd5;
            end else begin
                ker_we = 1'b0;
            end
            #1;
            if (stall && ov_s && stall_cnt < 5) begin
                chk("stall_pix_ready", pr_s, 0);
                if (stall_cnt == 0) begin
                    hold_d = od_s; hold_r = or_s; hold_c = oc_s;
                end else begin
                    chk("stall_data", od_s, hold_d);
                    chk("stall_row", or_s, hold_r);
                    chk("stall_col", oc_s, hold_c);
                end
                stall_cnt++;
            end
            if (ov_s && out_r) obs_q.push_back('{int'(od_s), int'(or_s), int'(oc_s)});
            if (pix_valid && pr_s) idx++;
            if (done_s) done_cnt++;
            if (done_cnt > 0) post++;
            cyc++;
            @(negedge clock);
        end
        pix_valid = 1'b0; ker_we = 1'b0; out_ready1 = 1'b1; out_ready2 = 1'b1;
    endtask

    task automatic compare_frame(input string tag);
        int n;
        chk({tag, "_count"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_data[%0d]", tag, i), obs_q[i].d, exp_q[i].d);
            chk($sformatf("%s_row[%0d]", tag, i),  obs_q[i].r, exp_q[i].r);
            chk($sformatf("%s_col[%0d]", tag, i),  obs_q[i].c, exp_q[i].c);
        end
        chk({tag, "_done_pulses"}, done_cnt, 1);
    endtask

    task automatic set_center(input int v);
        for (int i = 0; i < K; i++)
            for (int j = 0; j < K; j++)
                mk[i][j] = 0;
        mk[1][1] = v;
    endtask

    initial begin
        reset = 1'b1; start1 = 1'b0; start2 = 1'b0; ker_we = 1'b0;
        ker_row = '0; ker_col = '0; ker_data = '0; pix_valid = 1'b0; pix_data = '0;
        out_ready1 = 1'b1; out_ready2 = 1'b1;
        repeat (3) @(negedge clock);
        chk("rst_pix_ready", pr1, 0);
        chk("rst_out_valid", ov1, 0);
        chk("rst_out_data", od1, 0);
        chk("rst_out_row", or1, 0);
        chk("rst_out_col", oc1, 0);
        chk("rst_busy", busy1, 0);
        chk("rst_done", done1, 0);
        chk("rst_busy_s2", busy2, 0);
        reset = 1'b0;

        // Center-tap kernel over a ramp image
        for (int r = 0; r < SZ; r++)
            for (int c = 0; c < SZ; c++)
                img[r][c] = r*8 + c - 32;
        set_center(1);
        load_kernel();
        build_expected(1, 0);
        run_frame(1, 0, 0, 0, 0, 0);
        compare_frame("center");

        // Saturation both ways
        for (int i = 0; i < K; i++)
            for (int j = 0; j < K; j++)
                mk[i][j] = 1;
        load_kernel();
        fill_img(100, 100);
        build_expected(1, 0);
        run_frame(1, 0, 0, 0, 0, 0);
        compare_frame("sat_pos");
        fill_img(-100, -100);
        build_expected(1, 0);
        run_frame(1, 0, 0, 0, 0, 0);
        compare_frame("sat_neg");

        // Output held off for 5 cycles after the first result
        fill_img(-20, 20);
        fill_ker(-2, 2);
        load_kernel();
        build_expected(1, 0);
        run_frame(1, 0, 0, 1, 0, 0);
        compare_frame("stall");

        // Full-range random data with random backpressure
        fill_img(-128, 127);
        fill_ker(-128, 127);
        load_kernel();
        build_expected(1, 0);
        run_frame(1, 0, 1, 0, 0, 0);
        compare_frame("rand");

        // Kernel write during RUN is ignored, on the start cycle it lands
        for (int r = 0; r < SZ; r++)
            for (int c = 0; c < SZ; c++)
                img[r][c] = r*8 + c - 32;
        set_center(1);
        load_kernel();
        build_expected(1, 0);
        run_frame(1, 0, 0, 0, 1, 0);
        compare_frame("we_run");
        mk[1][1] = 5;
        build_expected(1, 0);
        run_frame(1, 0, 0, 0, 0, 1);
        compare_frame("we_start");

        // Stride 2, shift 2
        fill_img(-128, 127);
        fill_ker(-8, 8);
        load_kernel();
        build_expected(2, 2);
        run_frame(2, 0, 1, 0, 0, 0);
        compare_frame("stride");

        // Reset after 20 pixels aborts the frame and clears the kernel
        fill_img(-30, 30);
        fill_ker(-3, 3);
        load_kernel();
        run_frame(1, 20, 0, 0, 0, 0);
        reset = 1'b1;
        @(negedge clock);
        chk("abort_out_valid", ov1, 0);
        chk("abort_busy", busy1, 0);
        chk("abort_pix_ready", pr1, 0);
        chk("abort_done", done1, 0);
        chk("abort_out_data", od1, 0);
        reset = 1'b0;
        for (int i = 0; i < K; i++)
            for (int j = 0; j < K; j++)
                mk[i][j] = 0;
        build_expected(1, 0);
        run_frame(1, 0, 0, 0, 0, 0);
        compare_frame("post_reset_zero");
        fill_ker(-3, 3);
        load_kernel();
        build_expected(1, 0);
        run_frame(1, 0, 1, 0, 0, 0);
        compare_frame("post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
